// File: rtl/instruction_compressor.sv
// Instruction compressor: replaces known adjacent instruction pairs with a
// single token word drawn from a small programmable pair table. Words that do
// not pair up are emitted raw, so the output stream always expands back to the
// exact input sequence.
module instruction_compressor #(
    parameter int                       WIDTH         = 32,
    parameter int                       ENCODE_LENGTH = 4,
    parameter logic [ENCODE_LENGTH-1:0] OPCODE        = 4'b1111,
    parameter int                       ENTRIES       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_instr,
    input  logic                       flush,
    input  logic                       wme,
    input  logic [$clog2(ENTRIES)-1:0] waddr,
    input  logic [WIDTH-1:0]           wdata0,
    input  logic [WIDTH-1:0]           wdata1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_word,
    output logic                       out_token,
    output logic                       err_marker,
    output logic [15:0]                raw_count,
    output logic [15:0]                token_count
);

    localparam int ABITS = $clog2(ENTRIES);
    localparam int TOKW  = WIDTH - ENCODE_LENGTH;

    // Pair table: valid bits are resettable, the pair payload is plain storage.
    logic [ENTRIES-1:0] tv;
    logic [WIDTH-1:0]   t0 [ENTRIES];
    logic [WIDTH-1:0]   t1 [ENTRIES];

    // Pending instruction awaiting a possible partner.
    logic               pvalid;
    logic [WIDTH-1:0]   pinstr;

    logic               o_free;
    logic               transfer;
    logic               flush_fire;
    logic               hit;
    logic [ABITS-1:0]   hit_idx;
    logic [TOKW-1:0]    tok_low;
    logic               load;
    logic               load_token;
    logic [WIDTH-1:0]   load_word;
    logic               load_marker;

    assign o_free     = !out_valid || out_ready;
    assign in_ready   = !flush && o_free;
    assign transfer   = in_valid && in_ready;
    assign flush_fire = flush && pvalid && o_free;
    assign tok_low    = TOKW'(hit_idx) << 3;

    // Compare {pending, incoming} against every valid entry; lowest index wins.
    // Table registers hold pre-write contents, so a same-cycle write is not seen.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (tv[i] && t0[i] == pinstr && t1[i] == in_instr) begin
                hit     = 1'b1;
                hit_idx = ABITS'(i);
            end
        end
    end

    // Select what (if anything) is loaded into the output register this cycle.
    always_comb begin
        load       = 1'b0;
        load_token = 1'b0;
        load_word  = '0;
        if (transfer && pvalid) begin
            load = 1'b1;
            if (hit) begin
                load_token = 1'b1;
                load_word  = {OPCODE, tok_low};
            end else begin
                load_word  = pinstr;
            end
        end else if (flush_fire) begin
            load      = 1'b1;
            load_word = pinstr;
        end
    end

    assign load_marker = load && !load_token &&
                         (load_word[WIDTH-1 -: ENCODE_LENGTH] == OPCODE);

    // Table valid bits: cleared by reset, set by a write.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            tv <= '0;
        end else if (wme) begin
            tv[waddr] <= 1'b1;
        end
    end

    // Table payload: only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        // NOTE: the pair storage is deliberately not reset; the valid bits gate every read.
        if (wme) begin
            t0[waddr] <= wdata0;
            t1[waddr] <= wdata1;
        end
    end

    // Pending register: capture on unpaired transfer, release on match or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pvalid <= 1'b0;
            pinstr <= '0;
        end else if (transfer) begin
            if (pvalid && hit) begin
                pvalid <= 1'b0;
            end else begin
                pvalid <= 1'b1;
                pinstr <= in_instr;
            end
        end else if (flush_fire) begin
            pvalid <= 1'b0;
        end
    end

    // Output register: load has priority over drain so a word can move every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_token <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_word  <= load_word;
            out_token <= load_token;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_token <= 1'b0;
        end
    end

    // Sticky marker error and saturating emitted-word counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_marker  <= 1'b0;
            raw_count   <= '0;
            token_count <= '0;
        end else begin
            if (load_marker) begin
                err_marker <= 1'b1;
            end
            if (load && !load_token && raw_count != 16'hFFFF) begin
                raw_count <= raw_count + 16'd1;
            end
            if (load && load_token && token_count != 16'hFFFF) begin
                token_count <= token_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_compressor.sv
// Directed bench for instruction_compressor: pair tokenisation, raw fallback,
// backpressure, lowest-index priority, marker error and mid-run reset.
module tb_instruction_compressor;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        wme;
    logic [2:0]  waddr;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_token;
    logic        err_marker;
    logic [15:0] raw_count;
    logic [15:0] token_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] got_q[$];

    instruction_compressor dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .wme         (wme),
        .waddr       (waddr),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_token   (out_token),
        .err_marker  (err_marker),
        .raw_count   (raw_count),
        .token_count (token_count)
    );

    always #5 clk = ~clk;

    // Capture accepted output words halfway through the cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back({out_token, out_word});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        in_valid  = 1'b0;
        in_instr  = '0;
        flush     = 1'b0;
        wme       = 1'b0;
        waddr     = '0;
        wdata0    = '0;
        wdata1    = '0;
        out_ready = 1'b1;
        reset     = 1'b0;
        #2;
        reset     = 1'b1;
        tick();
        got_q.delete();
    endtask

    task automatic write_entry(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] b);
        wme    = 1'b1;
        waddr  = idx;
        wdata0 = a;
        wdata1 = b;
        tick();
        wme    = 1'b0;
    endtask

    task automatic send(input string tag, input logic [31:0] instr);
        int n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({tag, "_timeout"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp_word, input logic exp_tok);
        logic [32:0] e;
        check({tag, "_avail"}, 32'(got_q.size() != 0), 32'd1);
        if (got_q.size() != 0) begin
            e = got_q.pop_front();
            check({tag, "_word"}, e[31:0], exp_word);
            check({tag, "_tok"}, 32'(e[32]), 32'(exp_tok));
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        flush     = 1'b0;
        wme       = 1'b0;
        waddr     = '0;
        wdata0    = '0;
        wdata1    = '0;
        out_ready = 1'b1;
        #12;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_token", 32'(out_token), 32'd0);
        check("rst_err", 32'(err_marker), 32'd0);
        check("rst_raw_cnt", 32'(raw_count), 32'd0);
        check("rst_tok_cnt", 32'(token_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;

        // Known pair at entry 2 collapses to one token
        do_reset();
        write_entry(3'd2, 32'h00A00093, 32'h00108113);
        send("p2a", 32'h00A00093);
        send("p2b", 32'h00108113);
        do_flush();
        check("p2_count", 32'(got_q.size()), 32'd1);
        pop_check("p2", 32'hF0000010, 1'b1);
        check("p2_tok_cnt", 32'(token_count), 32'd1);
        check("p2_raw_cnt", 32'(raw_count), 32'd0);

        // Empty table: both words come out raw in order
        do_reset();
        send("r1", 32'h11111111);
        send("r2", 32'h22222222);
        do_flush();
        check("raw_count_q", 32'(got_q.size()), 32'd2);
        pop_check("raw1", 32'h11111111, 1'b0);
        pop_check("raw2", 32'h22222222, 1'b0);
        check("raw_cnt", 32'(raw_count), 32'd2);
        check("raw_tok_cnt", 32'(token_count), 32'd0);

        // Backpressure: hold for 5 cycles, then drain one word per cycle
        do_reset();
        out_ready = 1'b0;
        send("bp_x", 32'h0000AAAA);
        send("bp_y", 32'h0000BBBB);
        in_valid = 1'b1;
        in_instr = 32'h0000CCCC;
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_word", out_word, 32'h0000AAAA);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_drain1", 32'(got_q.size()), 32'd1);
        in_instr = 32'h0000DDDD;
        tick();
        check("bp_drain2", 32'(got_q.size()), 32'd2);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        check("bp_drain3", 32'(got_q.size()), 32'd3);
        flush = 1'b0;
        tick();
        check("bp_drain4", 32'(got_q.size()), 32'd4);
        check("bp_empty", 32'(out_valid), 32'd0);
        pop_check("bp_w0", 32'h0000AAAA, 1'b0);
        pop_check("bp_w1", 32'h0000BBBB, 1'b0);
        pop_check("bp_w2", 32'h0000CCCC, 1'b0);
        pop_check("bp_w3", 32'h0000DDDD, 1'b0);
        check("bp_raw_cnt", 32'(raw_count), 32'd4);

        // Duplicate entries: lowest index wins
        do_reset();
        write_entry(3'd5, 32'h12345678, 32'h9ABCDEF0);
        write_entry(3'd1, 32'h12345678, 32'h9ABCDEF0);
        send("dup_a", 32'h12345678);
        send("dup_b", 32'h9ABCDEF0);
        do_flush();
        check("dup_count", 32'(got_q.size()), 32'd1);
        pop_check("dup", 32'hF0000008, 1'b1);

        // Same-cycle write and compare sees the old table
        do_reset();
        send("wc_a", 32'h0C0C0C0C);
        wme      = 1'b1;
        waddr    = 3'd0;
        wdata0   = 32'h0C0C0C0C;
        wdata1   = 32'h0D0D0D0D;
        in_valid = 1'b1;
        in_instr = 32'h0D0D0D0D;
        tick();
        wme      = 1'b0;
        in_valid = 1'b0;
        do_flush();
        pop_check("wc_raw0", 32'h0C0C0C0C, 1'b0);
        pop_check("wc_raw1", 32'h0D0D0D0D, 1'b0);
        send("wc_c", 32'h0C0C0C0C);
        send("wc_d", 32'h0D0D0D0D);
        do_flush();
        pop_check("wc_tok", 32'hF0000000, 1'b1);

        // Raw word carrying the marker: emitted, sticky error
        do_reset();
        send("mk", 32'hF1234567);
        do_flush();
        pop_check("mk_raw", 32'hF1234567, 1'b0);
        check("mk_err", 32'(err_marker), 32'd1);
        send("mk_n1", 32'h00000001);
        send("mk_n2", 32'h00000002);
        do_flush();
        check("mk_err_held", 32'(err_marker), 32'd1);
        do_reset();
        check("mk_err_clr", 32'(err_marker), 32'd0);

        // Reset mid-operation discards pending/output words and empties the table
        write_entry(3'd3, 32'h0E0E0E0E, 32'h0F0F0F0F);
        out_ready = 1'b0;
        send("mr_g", 32'h01010101);
        send("mr_h", 32'h02020202);
        check("mr_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_word", out_word, 32'd0);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check("mr_no_word", 32'(got_q.size()), 32'd0);
        send("mr_e", 32'h0E0E0E0E);
        send("mr_f", 32'h0F0F0F0F);
        do_flush();
        pop_check("mr_raw0", 32'h0E0E0E0E, 1'b0);
        pop_check("mr_raw1", 32'h0F0F0F0F, 1'b0);
        check("mr_tok_cnt", 32'(token_count), 32'd0);
        check("mr_raw_cnt", 32'(raw_count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
